// File: rtl/stream_mux_rr.sv
// ============================================================================
// Module   : stream_mux_rr
// Purpose  : N-channel valid/ready stream mux, fixed-select or round-robin,
//            with a registered output slot.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_mux_rr #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 4,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]  rr_last_q,   rr_last_d;

    logic              w_accept;
    logic              w_grant_vld;
    logic [SEL_W-1:0]  w_grant_ch;
    logic              w_xfer;
    int                w_idx;

    assign w_accept = !out_valid_q || out_ready;

    // Round-robin scan runs from the farthest candidate back to the nearest,
    // so the last hit written is the first channel after rr_last.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_ch  = '0;
        w_idx       = 0;
        if (!mode) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    w_grant_vld = 1'b1;
                    w_grant_ch  = SEL_W'(i);
                end
            end
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                w_idx = (int'(rr_last_q) + k) % NUM_CH;
                if (in_valid[w_idx]) begin
                    w_grant_vld = 1'b1;
                    w_grant_ch  = SEL_W'(w_idx);
                end
            end
        end
    end

    assign w_xfer = !rst && w_accept && w_grant_vld;

    always_comb begin
        in_ready = '0;
        if (w_xfer) begin
            in_ready[w_grant_ch] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_last_d   = rr_last_q;
        if (w_accept) begin
            out_valid_d = w_xfer;
            if (w_xfer) begin
                out_data_d = in_data[int'(w_grant_ch)*DATA_W +: DATA_W];
                out_ch_d   = w_grant_ch;
                if (mode) begin
                    rr_last_d = w_grant_ch;
                end
            end
        end
    end

    // rr_last resets to the top channel so channel 0 wins the first scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_last_q   <= SEL_W'(NUM_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

`default_nettype wire
